// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared encodings for the data-memory arbiter.
//   - FSM state codes: IDLE, BURST, DONE.
//   - Read-return owner tag: OWN_NONE, OWN_CPU, OWN_DBG. The tag records who
//     issued the read whose data appears on mem_rdata in the following cycle.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t BURST = 2'd1;
    localparam state_t DONE  = 2'd2;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_CPU  = 2'd1;
    localparam owner_t OWN_DBG  = 2'd2;

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating counter of consecutive arbitration cycles in which the debug
//   port asked for the memory and lost. Once it saturates, debug wins.
//   Ports:
//     CLK, RESET  clock, asynchronous active-high reset
//     inc         count one more denied cycle (ignored once saturated)
//     clr         debug was granted; restart the count (wins over inc)
//     sat         count has reached STARVE_MAX
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    assign sat = (cnt_q == CNT_W'(STARVE_MAX));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one synchronous single-port RAM between the core load/store port
//   and a debug/loader burst port. The core has fixed priority, except that a
//   debug request denied STARVE_MAX arbitration cycles in a row wins the next
//   one. IDLE and DONE are arbitration cycles; BURST issues one debug beat per
//   cycle with the address wrapping modulo 2^ADDR_W.
//   Ports:
//     CLK, RESET                 clock, asynchronous active-high reset
//     cpu_req/we/addr/wdata      core access request
//     cpu_gnt                    access performed this cycle (combinational)
//     cpu_rvalid/rdata           core read data, one cycle after grant
//     dbg_req/we/addr/len/wdata  debug burst request (len = beats - 1)
//     dbg_gnt                    burst accepted (one-cycle pulse)
//     dbg_wready                 dbg_wdata consumed this cycle
//     dbg_rvalid/rdata           debug read beat data
//     dbg_done                   burst complete (one-cycle pulse)
//     mem_en/we/addr/wdata       RAM command
//     mem_rdata                  RAM read data, one cycle after a read enable
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int LEN_W      = 4
) (
    input  logic              CLK,
    input  logic              RESET,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [LEN_W-1:0]  dbg_len,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_wready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              we_q;

    logic              arb_cycle;
    logic              in_burst;
    logic              last_beat;
    logic              starve_sat;
    logic              cpu_win;
    logic              dbg_win;

    assign arb_cycle = (state_q == IDLE) || (state_q == DONE);
    assign in_burst  = (state_q == BURST);
    assign last_beat = (beat_q == len_q);

    // The grants are combinational, so they are gated with RESET directly to
    // keep them low for the whole reset pulse, not just after the state flops
    // have cleared.
    assign cpu_win = !RESET && arb_cycle && cpu_req && !(dbg_req && starve_sat);
    assign dbg_win = !RESET && arb_cycle && dbg_req && !cpu_win;

    assign cpu_gnt  = cpu_win;
    assign dbg_gnt  = dbg_win;
    assign dbg_done = (state_q == DONE);

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (arb_cycle && dbg_req && !dbg_win),
        .clr   (dbg_win),
        .sat   (starve_sat)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dbg_wready = 1'b0;
        if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : '0;
        end else if (in_burst) begin
            mem_en     = 1'b1;
            mem_we     = we_q;
            // Truncation to ADDR_W bits gives the 127 -> 0 wrap.
            mem_addr   = base_q + ADDR_W'(beat_q);
            mem_wdata  = we_q ? dbg_wdata : '0;
            dbg_wready = we_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = dbg_win ? BURST : IDLE;
            BURST:      state_d = last_beat ? DONE : BURST;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            // Tag the owner of the read issued this cycle so its data, which
            // arrives next cycle, is steered to the right port.
            if (cpu_win && !cpu_we) begin
                owner_q <= OWN_CPU;
            end else if (in_burst && !we_q) begin
                owner_q <= OWN_DBG;
            end else begin
                owner_q <= OWN_NONE;
            end

            if (dbg_win) begin
                base_q <= dbg_addr;
                len_q  <= dbg_len;
                we_q   <= dbg_we;
                beat_q <= '0;
            end else if (in_burst) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign dbg_rvalid = (owner_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural synchronous RAM.
//   Inputs change at posedge+1; outputs are sampled one time unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [LEN_W-1:0]  dbg_len;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt, dbg_wready, dbg_rvalid, dbg_done;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .LEN_W(LEN_W)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_len(dbg_len), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_wready(dbg_wready), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM: read data appears the cycle after enable.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_len = '0; dbg_wdata = '0;
    endtask

    logic [ADDR_W-1:0] wrap_addr [4] = '{7'd126, 7'd127, 7'd0, 7'd1};

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        mem_rdata = '0;
        ram[5]  = 32'h0000_0810;
        ram[10] = 32'h0000_1010;
        ram[11] = 32'h0000_1111;
        for (int i = 0; i < 4; i++) ram[40+i] = 32'hDEAD_0000 + i;

        // Reset: grants and mem_en stay low even with a pending request.
        RESET = 1;
        idle_inputs();
        cpu_req = 1; cpu_addr = 7'd5; dbg_req = 1;
        #2;
        check("rst_cpu_gnt",  cpu_gnt,  0);
        check("rst_dbg_gnt",  dbg_gnt,  0);
        check("rst_mem_en",   mem_en,   0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dbg_done", dbg_done, 0);
        check("rst_rvalids",  {cpu_rvalid, dbg_rvalid, dbg_wready}, 0);
        next_cycle();
        next_cycle();
        RESET = 0;
        idle_inputs();
        settle();
        check("post_rst_done", dbg_done, 0);

        // CPU read of addr 5, no debug traffic.
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
        settle();
        check("cpu_rd_gnt",      cpu_gnt,  1);
        check("cpu_rd_mem_en",   mem_en,   1);
        check("cpu_rd_mem_we",   mem_we,   0);
        check("cpu_rd_mem_addr", mem_addr, 5);
        next_cycle();
        cpu_req = 0;
        settle();
        check("cpu_rd_rvalid", cpu_rvalid, 1);
        check("cpu_rd_rdata",  cpu_rdata,  32'h0000_0810);
        check("cpu_rd_no_dbg", dbg_rvalid, 0);

        // CPU write: commits at the grant edge, produces no rvalid.
        cpu_req = 1; cpu_we = 1; cpu_addr = 7'd20; cpu_wdata = 32'hCAFE_F00D;
        settle();
        check("cpu_wr_gnt",   cpu_gnt,   1);
        check("cpu_wr_we",    mem_we,    1);
        check("cpu_wr_wdata", mem_wdata, 32'hCAFE_F00D);
        next_cycle();
        idle_inputs();
        settle();
        check("cpu_wr_no_rvalid", cpu_rvalid, 0);
        check("cpu_wr_ram",       ram[20],    32'hCAFE_F00D);

        // Wrapping 4-beat debug write at 126.
        next_cycle();
        dbg_req = 1; dbg_we = 1; dbg_addr = 7'd126; dbg_len = 4'd3;
        settle();
        check("wb_gnt",    dbg_gnt, 1);
        check("wb_no_mem", mem_en,  0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            dbg_req = 0;
            dbg_wdata = 32'hA0 + i;
            settle();
            check("wb_wready", dbg_wready, 1);
            check("wb_mem_we", mem_we,     1);
            check("wb_addr",   mem_addr,   wrap_addr[i]);
            check("wb_wdata",  mem_wdata,  32'hA0 + i);
            check("wb_no_done", dbg_done,  0);
        end
        next_cycle();
        idle_inputs();
        settle();
        check("wb_done",        dbg_done,   1);
        check("wb_done_wready", dbg_wready, 0);
        check("wb_done_mem_en", mem_en,     0);
        next_cycle();
        settle();
        check("wb_done_pulse", dbg_done, 0);
        check("wb_ram126", ram[126], 32'hA0);
        check("wb_ram127", ram[127], 32'hA1);
        check("wb_ram0",   ram[0],   32'hA2);
        check("wb_ram1",   ram[1],   32'hA3);

        // Starvation, then a 2-beat read burst with the CPU still requesting.
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'd10; dbg_len = 4'd1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("sv_cpu_gnt", cpu_gnt, 1);
            check("sv_dbg_gnt", dbg_gnt, 0);
            next_cycle();
        end
        settle();
        check("sv_cpu_stall", cpu_gnt,    0);
        check("sv_dbg_win",   dbg_gnt,    1);
        check("sv_no_mem",    mem_en,     0);
        check("sv_cpu_rv",    cpu_rvalid, 1);
        check("sv_cpu_rd",    cpu_rdata,  32'h0000_0810);
        next_cycle();
        dbg_req = 0;
        settle();
        check("rb0_cpu_stall", cpu_gnt,    0);
        check("rb0_addr",      mem_addr,   10);
        check("rb0_we",        mem_we,     0);
        check("rb0_no_rv",     {cpu_rvalid, dbg_rvalid}, 0);
        next_cycle();
        settle();
        check("rb1_cpu_stall", cpu_gnt,    0);
        check("rb1_addr",      mem_addr,   11);
        check("rb1_dbg_rv",    dbg_rvalid, 1);
        check("rb1_dbg_rd",    dbg_rdata,  32'h0000_1010);
        check("rb1_cpu_rv",    cpu_rvalid, 0);
        next_cycle();
        settle();
        check("rbd_done",    dbg_done,   1);
        check("rbd_cpu_gnt", cpu_gnt,    1);
        check("rbd_dbg_rv",  dbg_rvalid, 1);
        check("rbd_dbg_rd",  dbg_rdata,  32'h0000_1111);
        check("rbd_cpu_rv",  cpu_rvalid, 0);
        next_cycle();
        idle_inputs();
        settle();
        check("rbx_cpu_rv", cpu_rvalid, 1);
        check("rbx_cpu_rd", cpu_rdata,  32'h0000_0810);
        check("rbx_dbg_rv", dbg_rvalid, 0);
        check("rbx_done",   dbg_done,   0);

        // Reset during beat 2 of a 4-beat write at 40.
        next_cycle();
        dbg_req = 1; dbg_we = 1; dbg_addr = 7'd40; dbg_len = 4'd3;
        settle();
        check("rm_gnt", dbg_gnt, 1);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            dbg_req = 0;
            dbg_wdata = 32'hB0 + i;
            settle();
            check("rm_wready", dbg_wready, 1);
        end
        next_cycle();
        dbg_wdata = 32'hB2;
        RESET = 1;
        settle();
        check("rm_mem_en", mem_en,     0);
        check("rm_wready", dbg_wready, 0);
        check("rm_done",   dbg_done,   0);
        check("rm_gnts",   {cpu_gnt, dbg_gnt}, 0);
        next_cycle();
        RESET = 0;
        idle_inputs();
        settle();
        check("rm_after_done", dbg_done, 0);
        check("rm_after_rv",   {cpu_rvalid, dbg_rvalid}, 0);
        check("rm_ram40", ram[40], 32'hB0);
        check("rm_ram41", ram[41], 32'hB1);
        check("rm_ram42", ram[42], 32'hDEAD_0002);
        check("rm_ram43", ram[43], 32'hDEAD_0003);

        // New single-beat debug read after reset.
        next_cycle();
        dbg_req = 1; dbg_we = 0; dbg_addr = 7'd41; dbg_len = 4'd0;
        settle();
        check("nr_gnt", dbg_gnt, 1);
        next_cycle();
        dbg_req = 0;
        settle();
        check("nr_addr", mem_addr, 41);
        next_cycle();
        settle();
        check("nr_done", dbg_done,   1);
        check("nr_rv",   dbg_rvalid, 1);
        check("nr_rd",   dbg_rdata,  32'hB1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
